// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential array multiplier: FSM state encoding,
// counter sizing and a wide two's-complement negate used for signed results.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest product the negate helper supports; callers truncate to 2N bits.
    localparam int NEG_MAX_W = 128;

    // Bits needed for a step counter that runs from 0 up to n/k inclusive.
    function automatic int count_width(input int n, input int k);
        return $clog2(n / k + 1);
    endfunction

    // Two's-complement negate; the low 2N bits are the 2N-bit negation.
    function automatic logic [NEG_MAX_W-1:0] negate_2c(input logic [NEG_MAX_W-1:0] v);
        return ~v + NEG_MAX_W'(1);
    endfunction

endpackage

// File: rtl/mult_pp_row.sv
// Combinational K-row slice of the array multiplier: adds mag_a times K
// multiplier bits, placed at bit offset count*K, into a 2N-bit running sum.
// Each row is a 2N-bit ripple chain of full adders, as in the original
// combinational array; the final carry-out is dropped because the full
// product always fits in 2N bits.
module mult_pp_row #(
    parameter int N  = 8,
    parameter int K  = 2,
    parameter int CW = 3
) (
    input  logic [N-1:0]   mag_a,
    input  logic [K-1:0]   b_bits,
    input  logic [CW-1:0]  count,
    input  logic [2*N-1:0] sum_in,
    output logic [2*N-1:0] sum_out
);

    localparam int SHW = $clog2(2 * N) + 1;

    logic [2*N-1:0] ext_a;
    logic [SHW-1:0] base_shift;
    logic [2*N-1:0] run_sum;
    logic [2*N-1:0] addend;
    logic           carry;
    logic           gen;
    logic           prop;

    assign ext_a      = {{N{1'b0}}, mag_a};
    assign base_shift = SHW'(count) * SHW'(K);

    // Ripple each gated, shifted copy of mag_a through its own full-adder row.
    always_comb begin
        run_sum = sum_in;
        addend  = '0;
        carry   = 1'b0;
        gen     = 1'b0;
        prop    = 1'b0;
        for (int j = 0; j < K; j++) begin
            addend = b_bits[j] ? (ext_a << (base_shift + SHW'(j))) : '0;
            carry  = 1'b0;
            for (int i = 0; i < 2 * N; i++) begin
                gen        = run_sum[i] & addend[i];
                prop       = run_sum[i] ^ addend[i];
                run_sum[i] = prop ^ carry;
                carry      = gen | (prop & carry);
            end
        end
        sum_out = run_sum;
    end

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative N x N multiplier retiring K multiplier bits per clock, with
// signed/unsigned selection per transaction and valid/ready on both sides.
// Operands are converted to magnitudes on accept and the sign is reapplied
// once at the end, so the adder array only ever sees unsigned values.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always taking N/K steps.
module seq_array_multiplier #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    import seq_mult_pkg::*;

    localparam int STEPS = N / K;
    localparam int CW    = count_width(N, K);

    if (N < 2) begin : g_bad_n
        $error("seq_array_multiplier: N must be at least 2");
    end
    if (K < 1 || (N % K) != 0) begin : g_bad_k
        $error("seq_array_multiplier: K must divide N");
    end
    if (2 * N > NEG_MAX_W) begin : g_bad_w
        $error("seq_array_multiplier: 2N exceeds negate helper width");
    end

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic           neg;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  count;

    logic [N-1:0]   a_abs;
    logic [N-1:0]   b_abs;
    logic [2*N-1:0] acc_sum;
    logic [2*N-1:0] result;
    logic           last_step;

    assign a_abs = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
    assign b_abs = (is_signed && b[N-1]) ? (~b + N'(1)) : b;

    mult_pp_row #(
        .N  (N),
        .K  (K),
        .CW (CW)
    ) u_row (
        .mag_a   (mag_a),
        .b_bits  (mag_b[K-1:0]),
        .count   (count),
        .sum_in  (acc),
        .sum_out (acc_sum)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last_step = (count == CW'(STEPS - 1)) || ((mag_b >> K) == '0);
`else
    assign last_step = (count == CW'(STEPS - 1));
`endif

    assign result = neg ? (2*N)'(negate_2c(NEG_MAX_W'(acc_sum))) : acc_sum;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, iterate, then wait for the result handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            CALC:    busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // Datapath: capture magnitudes on accept, accumulate K bits per step,
    // and register the sign-corrected product on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= a_abs;
                        mag_b <= b_abs;
                        neg   <= is_signed & (a[N-1] ^ b[N-1]);
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    mag_b <= mag_b >> K;
                    count <= count + CW'(1);
                    if (last_step) begin
                        product <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier (N=8, K=2). A cycle-level
// reference tracks accept/latency/handshake using plain integer products and
// a latency rule; a compare process checks every cycle, and directed cases
// pin the reference with hand-computed literals.
module tb_seq_array_multiplier;

    localparam int N     = 8;
    localparam int K     = 2;
    localparam int STEPS = N / K;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           is_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic           m_busy = 1'b0;
    logic           m_ov   = 1'b0;
    logic [2*N-1:0] m_exp  = '0;
    logic [2*N-1:0] m_prod = '0;
    int             m_cnt  = 0;
    int             m_lat  = 0;

    seq_array_multiplier #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] av, input logic [N-1:0] bv,
                                                   input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(av)) : longint'(av);
        y = s ? longint'($signed(bv)) : longint'(bv);
        return (2*N)'(x * y);
    endfunction

    function automatic int ref_latency(input logic [N-1:0] bv, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
        longint m;
        int     msb;
        int     lat;
        m = s ? longint'($signed(bv)) : longint'(bv);
        if (m < 0) m = -m;
        msb = -1;
        for (int i = 0; i < N; i++) begin
            if (m[i]) msb = i;
        end
        lat = (msb + 1 + K - 1) / K;
        if (lat < 1) lat = 1;
        return lat;
`else
        return STEPS + 0 * int'(bv) + 0 * int'(s);
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-level reference: accept when idle, count latency, release on out_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_ov   <= 1'b0;
            m_prod <= '0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_lat  <= ref_latency(b, is_signed);
                m_exp  <= ref_product(a, b, is_signed);
            end
        end else if (!m_ov) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                m_ov   <= 1'b1;
                m_prod <= m_exp;
            end
        end else if (out_ready) begin
            m_ov   <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // Compare DUT against the reference on every falling edge.
    always @(negedge clk) begin
        checkOutput("in_ready", in_ready, !m_busy);
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("busy", busy, m_busy);
        checkOutput("product", product, m_prod);
    end

    // One transaction: present operands, count edges to out_valid, hold
    // off the consumer for 'hold' cycles, then complete the handshake.
    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic s,
                                 input int hold, input logic pulse,
                                 output logic [2*N-1:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("wait_in_ready", in_ready, 1);
        a         = av;
        b         = bv;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            checkOutput("in_ready_during_calc", in_ready, 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) checkOutput("out_valid_timeout", out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = (i % 2 == 0);
                a        = 8'h01;
                b        = 8'h01;
            end
            @(negedge clk);
            checkOutput("in_ready_held", in_ready, 0);
        end
        res       = product;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        bad++;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2*N-1:0] res;
        int             lat;
        int             guard;
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        logic           rs;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_product", product, 0);

        $display("[TB] unsigned extreme");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 1'b0, res, lat);
        checkOutput("u255x255", res, 16'hFE01);
        checkOutput("u255x255_lat", lat, 4);

        $display("[TB] signed cases");
        applyStimulus(8'h80, 8'h80, 1'b1, 0, 1'b0, res, lat);
        checkOutput("s_m128sq", res, 16'h4000);
        checkOutput("s_m128sq_lat", lat, 4);
        applyStimulus(8'hFD, 8'h05, 1'b1, 0, 1'b0, res, lat);
        checkOutput("s_m3x5", res, 16'hFFF1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        checkOutput("s_m3x5_lat", lat, 2);
`else
        checkOutput("s_m3x5_lat", lat, 4);
`endif

        $display("[TB] backpressure");
        applyStimulus(8'd12, 8'd10, 1'b0, 5, 1'b1, res, lat);
        checkOutput("bp_12x10", res, 16'h0078);

        $display("[TB] reset mid-calc");
        @(negedge clk);
        a = 8'd100; b = 8'd100; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_product", product, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd3, 8'd4, 1'b0, 0, 1'b0, res, lat);
        checkOutput("post_rst_3x4", res, 16'h000C);

        $display("[TB] back-to-back");
        @(negedge clk);
        a = 8'd20; b = 8'd30; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'hF6; b = 8'd7; is_signed = 1'b1;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("b2b_first", product, 16'h0258);
        @(negedge clk);
        checkOutput("b2b_gap_in_ready", in_ready, 1);
        @(negedge clk);
        checkOutput("b2b_second_accepted", busy, 1);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("b2b_second", product, 16'hFFBA);
        @(negedge clk);
        out_ready = 1'b0;

        $display("[TB] small multipliers");
        applyStimulus(8'd7, 8'd3, 1'b0, 0, 1'b0, res, lat);
        checkOutput("u7x3", res, 16'h0015);
`ifdef SEQ_MULT_EARLY_TERM_EN
        checkOutput("u7x3_lat", lat, 1);
`else
        checkOutput("u7x3_lat", lat, 4);
`endif
        applyStimulus(8'd0, 8'd0, 1'b0, 0, 1'b0, res, lat);
        checkOutput("u0x0", res, 16'h0000);
`ifdef SEQ_MULT_EARLY_TERM_EN
        checkOutput("u0x0_lat", lat, 1);
`else
        checkOutput("u0x0_lat", lat, 4);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            applyStimulus(ra, rb, rs, int'($urandom_range(0, 3)), 1'b0, res, lat);
            checkOutput("rand_product", res, ref_product(ra, rb, rs));
            checkOutput("rand_latency", lat, ref_latency(rb, rs));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
